fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch and issue sequencer that drives the opcode side of the main control decoder. It holds the program counter, fetches 32-bit instruction words from instruction memory with a ready handshake, and presents each word and its opcode to the control decoder and datapath. It then consumes the decoder's Beq/Bne/Jump outputs plus the ALU zero flag to pick the next PC. Illegal opcodes latch a trap.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; high only in FETCH state.
- imem_addr  output  32  fetch address; equals pc.
- imem_ready  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word from memory.
- instr  output  32  instruction register.
- opcode  output  6  instr[31:26]; feeds the control decoder.
- instr_valid  output  1  instr/opcode valid and awaiting retire.
- instr_ack  input  1  datapath retires current instruction.
- Beq  input  1  decoder branch-if-equal.
- Bne  input  1  decoder branch-if-not-equal.
- Jump  input  1  decoder jump.
- zero  input  1  ALU zero flag for the current instruction.
- pc  output  32  address of current/next-to-fetch instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32.
- trap  output  1  illegal opcode encountered; sticky.
- retired  output  32  count of retired instructions.

## Operation
- Legal opcodes: 000000 (R-type), 100011 (lw), 101011 (sw), 000100 (beq), 000101 (bne), 000010 (j). All others are illegal.
- States: FETCH, ISSUE, TRAP.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready with a legal opcode: instr<=imem_rdata, go to ISSUE.
  - On imem_ready with an illegal opcode: instr<=imem_rdata, trap<=1, go to TRAP.
  - Without imem_ready: stay in FETCH with the request held.
- ISSUE:
  - instr_valid=1, imem_req=0.
  - On instr_ack: pc<=next_pc, retired<=retired+1, go to FETCH.
  - Without instr_ack: hold all state.
- TRAP:
  - instr_valid=0, imem_req=0; pc and instr hold the faulting values.
  - Only reset exits TRAP.
- next_pc, evaluated on the ack cycle only:
  - If Jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Else if (Beq & zero) | (Bne & ~zero): pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - Else: pc_plus4.
- Jump has priority over any branch. If Beq and Bne are both high, the branch is always taken.
- All PC arithmetic is 32-bit and wraps modulo 2^32. retired wraps from FFFF_FFFF to 0.
- imem_ready is ignored outside FETCH. instr_ack is ignored outside ISSUE. Beq/Bne/Jump/zero are ignored except on an ISSUE ack cycle.

## Timing
- Reset values: state FETCH, pc=RESET_PC, instr=0, instr_valid=0, trap=0, retired=0. imem_req is gated to 0 while reset is high.
- Reset mid-operation takes effect on the next edge from any state. In-flight fetches and ack are discarded.
- The first imem_req is on the cycle after reset deasserts.
- imem_ready may arrive in the same cycle as imem_req. instr_valid then rises on the next cycle.
- Minimum throughput is 2 cycles per instruction (FETCH, ISSUE). Each cycle of imem_ready delay adds one cycle.
- instr_ack in the first ISSUE cycle returns to FETCH on the next edge, at the new pc.
- pc, pc_plus4, opcode and instr_valid are registered or decoded directly from state/registers. There is no combinational path from inputs to outputs except imem_req gating by reset.

## Test plan
- Reset with RESET_PC=0. Memory returns 0x012A4020 (R-type) with zero wait. Ack in the first ISSUE cycle -> pc=0 then 4; retired=1; imem_req pattern 1,0,1.
- imem_ready delayed 3 cycles -> imem_req held high 4 cycles, imem_addr stable, instr_valid rises one cycle after ready.
- At pc=0x100, instr 0x1000FFFE (beq, imm -2):
  - Beq=1, zero=1 on ack -> pc=0x0FC.
  - Same instruction with zero=0 -> pc=0x104.
- At pc=0x0FFF_FFFC, j instr 0x08000010 with Jump=1 -> pc=0x1000_0040. Same cycle with Beq=1, zero=1 -> Jump still wins.
- Fetch opcode 111011 -> trap=1 next cycle; instr_valid stays 0; imem_req 0; pc frozen; ack ignored for 10 cycles. Then reset -> trap=0, pc=RESET_PC.
- Reset asserted during ISSUE with ack high -> retired not incremented; pc=RESET_PC; state FETCH.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: owns the PC, fetches words with a ready
// handshake, presents them to the decoder and resolves jump/branch targets.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        Beq,
    input  logic        Bne,
    input  logic        Jump,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        TRAP  = 2'd2
    } state_t;

    localparam int NUM_LEGAL = 6;
    localparam logic [NUM_LEGAL-1:0][5:0] LEGAL_OPS = {
        6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010
    };

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] retired_reg;
    logic        trap_reg;

    logic [NUM_LEGAL-1:0] op_match;
    logic                 fetched_legal;
    logic                 branch_taken;
    logic [31:0]          pc_plus4_next;
    logic [31:0]          pc_next;

    // Legality is judged on the word arriving from memory, before it is latched.
    generate
        for (genvar gi = 0; gi < NUM_LEGAL; gi++) begin : g_legal
            assign op_match[gi] = (imem_rdata[31:26] == LEGAL_OPS[gi]);
        end
    endgenerate

    assign fetched_legal = |op_match;
    assign pc_plus4_next = pc_reg + 32'd4;

    always_comb begin
        branch_taken = (Beq & zero) | (Bne & ~zero);
        if (Jump) begin
            pc_next = {pc_plus4_next[31:28], instr_reg[25:0], 2'b00};
        end else if (branch_taken) begin
            pc_next = pc_plus4_next + {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
        end else begin
            pc_next = pc_plus4_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            instr_reg   <= 32'd0;
            retired_reg <= 32'd0;
            trap_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        instr_reg <= imem_rdata;
                        if (fetched_legal) begin
                            state_reg <= ISSUE;
                        end else begin
                            trap_reg  <= 1'b1;
                            state_reg <= TRAP;
                        end
                    end
                end
                ISSUE: begin
                    if (instr_ack) begin
                        pc_reg      <= pc_next;
                        retired_reg <= retired_reg + 32'd1;
                        state_reg   <= FETCH;
                    end
                end
                TRAP: begin
                    state_reg <= TRAP;
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    // The request is the only output with a path from an input (reset gating).
    assign imem_req    = (state_reg == FETCH) && !reset;
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign opcode      = instr_reg[31:26];
    assign instr_valid = (state_reg == ISSUE);
    assign pc          = pc_reg;
    assign pc_plus4    = pc_plus4_next;
    assign trap        = trap_reg;
    assign retired     = retired_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written
// trap/reset sequences and a randomized run against a rule-level PC model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ack;
    logic        Beq, Bne, Jump, zero;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] retired;

    fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .Beq(Beq), .Bne(Bne), .Jump(Jump), .zero(zero),
        .pc(pc), .pc_plus4(pc_plus4), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_pc;
    logic [31:0] model_retired;

    typedef struct {
        logic [31:0] ins;
        int          waitc;
        int          ackd;
        logic        beq, bne, jmp, z;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Next PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic b, input logic bn, input logic j,
                                             input logic z);
        logic [31:0] p4;
        int signed   imm;
        p4  = cur + 32'd4;
        imm = int'($signed(ins[15:0]));
        if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if ((b && z) || (bn && !z)) return p4 + 32'(imm * 4);
        return p4;
    endfunction

    task automatic clear_inputs();
        imem_ready = 1'b0; imem_rdata = 32'd0; instr_ack = 1'b0;
        Beq = 1'b0; Bne = 1'b0; Jump = 1'b0; zero = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_retired", retired, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        model_pc = RESET_PC;
        model_retired = 32'd0;
    endtask

    // One complete fetch/issue/retire transaction, entered at a negedge in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int waitc, input int ackd,
                             input logic b, input logic bn, input logic j, input logic z,
                             input logic [31:0] exp_pc);
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, model_pc);
        imem_ready = 1'b0;
        for (int i = 0; i < waitc; i++) begin
            @(negedge clk);
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, model_pc);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        imem_ready = 1'b0;
        check("issue_valid", {31'd0, instr_valid}, 32'd1);
        check("issue_instr", instr, ins);
        check("issue_opcode", {26'd0, opcode}, {26'd0, ins[31:26]});
        check("issue_req", {31'd0, imem_req}, 32'd0);
        check("issue_pc", pc, model_pc);
        check("issue_pc4", pc_plus4, model_pc + 32'd4);
        for (int i = 0; i < ackd; i++) begin
            imem_ready = 1'($urandom); imem_rdata = $urandom;
            Beq = 1'($urandom); Bne = 1'($urandom); Jump = 1'($urandom); zero = 1'($urandom);
            @(negedge clk);
            check("hold_instr", instr, ins);
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_pc", pc, model_pc);
        end
        imem_ready = 1'b0;
        instr_ack = 1'b1; Beq = b; Bne = bn; Jump = j; zero = z;
        @(negedge clk);
        clear_inputs();
        $display("[TB] txn pc=%h instr=%h beq=%0b bne=%0b j=%0b z=%0b -> pc=%h",
                 model_pc, ins, b, bn, j, z, pc);
        model_pc = exp_pc;
        model_retired = model_retired + 32'd1;
        check("ack_pc", pc, model_pc);
        check("ack_retired", retired, model_retired);
        check("ack_valid", {31'd0, instr_valid}, 32'd0);
        check("ack_req", {31'd0, imem_req}, 32'd1);
        check("ack_trap", {31'd0, trap}, 32'd0);
    endtask

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010};

        //          instr          wait ackd beq bne  j   z   expected pc
        vecs[0]  = '{32'h012A4020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
        vecs[1]  = '{32'h08000040, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
        vecs[2]  = '{32'h1000FFFE, 0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00FC};
        vecs[3]  = '{32'h08000040, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
        vecs[4]  = '{32'h1000FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0104};
        vecs[5]  = '{32'h14000003, 2, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0114};
        vecs[6]  = '{32'h14000003, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0118};
        vecs[7]  = '{32'h10000004, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_012C};
        vecs[8]  = '{32'h8C000000, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0130};
        vecs[9]  = '{32'h0BFFFFFF, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC};
        vecs[10] = '{32'h08000010, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_0040};
        vecs[11] = '{32'hAC000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0044};

        do_reset();
        foreach (vecs[k]) begin
            run_instr(vecs[k].ins, vecs[k].waitc, vecs[k].ackd,
                      vecs[k].beq, vecs[k].bne, vecs[k].jmp, vecs[k].z, vecs[k].exp_pc);
        end

        // Randomized stream of legal instructions with arbitrary decoder flags.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ins;
            logic b, bn, j, z;
            ins = {legal_ops[$urandom_range(0, 5)], 26'($urandom)};
            b = 1'($urandom); bn = 1'($urandom); z = 1'($urandom);
            j = ($urandom_range(0, 3) == 0);
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 2), b, bn, j, z,
                      ref_next(model_pc, ins, b, bn, j, z));
        end

        // Illegal opcode: trap latches, everything freezes until reset.
        do_reset();
        run_instr(32'h012A4020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        imem_ready = 1'b1;
        imem_rdata = 32'hEC00_1234;
        @(negedge clk);
        check("trap_set", {31'd0, trap}, 32'd1);
        check("trap_instr", instr, 32'hEC00_1234);
        for (int i = 0; i < 10; i++) begin
            instr_ack = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h012A4020;
            Jump = 1'($urandom); Beq = 1'($urandom); zero = 1'($urandom);
            @(negedge clk);
            check("trap_hold", {31'd0, trap}, 32'd1);
            check("trap_valid", {31'd0, instr_valid}, 32'd0);
            check("trap_req", {31'd0, imem_req}, 32'd0);
            check("trap_pc", pc, 32'h0000_0004);
            check("trap_instr_hold", instr, 32'hEC00_1234);
            check("trap_retired", retired, 32'd1);
        end
        $display("[TB] txn trap at pc=%h instr=%h", pc, instr);
        do_reset();

        // Reset while an ack is being presented discards the retirement.
        imem_ready = 1'b1;
        imem_rdata = 32'h012A4020;
        @(negedge clk);
        imem_ready = 1'b0;
        check("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        reset = 1'b1; instr_ack = 1'b1; Jump = 1'b1;
        @(negedge clk);
        check("rst_issue_retired", retired, 32'd0);
        check("rst_issue_pc", pc, RESET_PC);
        check("rst_issue_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_issue_req", {31'd0, imem_req}, 32'd0);
        clear_inputs();
        reset = 1'b0;
        #1;
        check("rst_issue_fetch", {31'd0, imem_req}, 32'd1);
        $display("[TB] txn reset during issue, pc=%h retired=%0d", pc, retired);
        @(negedge clk);
        run_instr(32'h8C000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, RESET_PC + 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
